// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core and its program loader.
// Holds the ImmSrc field-format encodings, the bit positions of each
// immediate field inside an instruction word, and the state encoding
// used by the instruction encoder's load sequencer.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int IMM_W  = 8;

    // ImmSrc encodings, shared with the core's immediate extraction
    localparam logic [1:0] IMM8     = 2'b00;
    localparam logic [1:0] IMM6S    = 2'b01;
    localparam logic [1:0] IMM5U    = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    // Field placement inside the instruction word
    localparam int IMM8_LSB  = 1;
    localparam int IMM8_MSB  = 8;
    localparam int IMM6S_LSB = 0;
    localparam int IMM6S_MSB = 5;
    localparam int IMM5U_LSB = 1;
    localparam int IMM5U_MSB = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } enc_state_t;

endpackage

// File: rtl/imm_field_inserter.sv
// Combinational immediate-field inserter.
// Merges a signed 8-bit immediate into the field selected by in_imm_src,
// leaving every other bit of in_base untouched, and reports whether the
// immediate is representable in that field.
// Ports:
//   in_base    [15:0]  instruction template
//   in_imm     [7:0]   signed immediate
//   in_imm_src [1:0]   field format (ImmSrc encoding)
//   enc_word   [15:0]  template with the field overwritten
//   fits               immediate is representable in the selected field
module imm_field_inserter
    import cpu_pkg::*;
(
    input  logic        [WORD_W-1:0] in_base,
    input  logic signed [IMM_W-1:0]  in_imm,
    input  logic        [1:0]        in_imm_src,
    output logic        [WORD_W-1:0] enc_word,
    output logic                     fits
);

    // A 6-bit signed field holds the value iff bits [7:5] are all copies
    // of the field's sign bit.
    function automatic logic fits_signed6(input logic signed [IMM_W-1:0] v);
        return (v[7:5] == {3{v[5]}});
    endfunction

    // A 5-bit unsigned field holds the value iff the upper three bits
    // (including the sign) are zero.
    function automatic logic fits_unsigned5(input logic signed [IMM_W-1:0] v);
        return (v[7:5] == 3'b000);
    endfunction

    always_comb begin
        enc_word = in_base;
        fits     = 1'b1;
        case (in_imm_src)
            IMM8: begin
                enc_word[IMM8_MSB:IMM8_LSB] = in_imm;
            end
            IMM6S: begin
                enc_word[IMM6S_MSB:IMM6S_LSB] = in_imm[IMM6S_MSB-IMM6S_LSB:0];
                fits = fits_signed6(in_imm);
            end
            IMM5U: begin
                enc_word[IMM5U_MSB:IMM5U_LSB] = in_imm[IMM5U_MSB-IMM5U_LSB:0];
                fits = fits_unsigned5(in_imm);
            end
            default: begin
                enc_word = in_base;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming instruction packer for the program loader.
// Accepts base word + signed immediate + ImmSrc format, range-checks the
// immediate, inserts it and writes each encodable word to instruction
// memory at an auto-incrementing address. Rejected words are counted but
// not written.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, start_addr,       begin a load at start_addr with word_count words
//   word_count
//   in_valid / in_ready      input handshake
//   in_base, in_imm,         word to encode
//   in_imm_src
//   imem_we, imem_addr,      registered instruction-memory write port
//   imem_wdata
//   busy                     load in progress (RUN or DRAIN)
//   done                     one-cycle completion pulse
//   err, err_count           sticky range error and rejected-word count
module instruction_encoder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic        [ADDR_W-1:0] start_addr,
    input  logic        [ADDR_W:0]   word_count,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [WORD_W-1:0] in_base,
    input  logic signed [IMM_W-1:0]  in_imm,
    input  logic        [1:0]        in_imm_src,
    output logic                     imem_we,
    output logic        [ADDR_W-1:0] imem_addr,
    output logic        [WORD_W-1:0] imem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic        [ADDR_W:0]   err_count
);

    localparam int CNT_W = ADDR_W + 1;

    enc_state_t         state, state_nxt;
    logic [CNT_W-1:0]   wcount_q;
    logic [CNT_W-1:0]   accepted_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               done_q;
    logic               err_q;
    logic [CNT_W-1:0]   err_count_q;

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [WORD_W-1:0]  wdata_p1;

    logic [WORD_W-1:0]  enc_word_p0;
    logic               fits_p0;
    logic               start_ok;
    logic               xfer_p0;
    logic               last_xfer_p0;

    imm_field_inserter u_ins (
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .enc_word   (enc_word_p0),
        .fits       (fits_p0)
    );

    // start is only honoured between loads
    assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign xfer_p0      = in_valid && in_ready;
    assign last_xfer_p0 = xfer_p0 && ((accepted_q + CNT_W'(1)) == wcount_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = (word_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_xfer_p0) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and counters
    always_comb begin
        in_ready = (state == ST_RUN) && (accepted_q < wcount_q);
        busy     = (state == ST_RUN) || (state == ST_DRAIN);
    end

    // Load counters, error tracking and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q    <= '0;
            accepted_q  <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            // Pulse on entry to DONE, including a zero-length restart from DONE
            done_q <= (state_nxt == ST_DONE) && ((state != ST_DONE) || start_ok);
            if (start_ok) begin
                wcount_q    <= word_count;
                accepted_q  <= '0;
                addr_q      <= start_addr;
                err_q       <= 1'b0;
                err_count_q <= '0;
            end else if (xfer_p0) begin
                // Rejected words still consume a slot of the load
                accepted_q <= accepted_q + CNT_W'(1);
                if (fits_p0) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    err_q       <= 1'b1;
                    err_count_q <= err_count_q + CNT_W'(1);
                end
            end
        end
    end

    // ---- p0 -> p1: registered write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0 && fits_p0;
            if (xfer_p0 && fits_p0) begin
                addr_p1  <= addr_q;
                wdata_p1 <= enc_word_p0;
            end
        end
    end

    assign imem_we    = vld_p1;
    assign imem_addr  = addr_p1;
    assign imem_wdata = wdata_p1;
    assign done       = done_q;
    assign err        = err_q;
    assign err_count  = err_count_q;

endmodule
